// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-requester round-robin arbiter in front of a single IO bus.
// One transaction is outstanding at a time: IDLE -> BUSY -> DONE -> IDLE.
// BUSY cycles are counted, and a stalled slave is answered with an error after
// TIMEOUT_CYCLES.
// Optional feature macro: IO_ARB_ATOMIC_LOCK_EN. When it is defined, an AMO lock
// read keeps the grant on the requester that issued it until that requester
// issues an AMO unlock write.

`ifndef ADDR_TAG_MODE_NORMAL
`define ADDR_TAG_MODE_NORMAL 2'b00
`endif
`ifndef ADDR_TAG_MODE_AMO
`define ADDR_TAG_MODE_AMO 2'b01
`endif
`ifndef ADDR_TAG_LOCK
`define ADDR_TAG_LOCK 1'b1
`endif
`ifndef ADDR_TAG_UNLOCK
`define ADDR_TAG_UNLOCK 1'b0
`endif

module io_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_stb_i,
  input  logic [31:0] m0_addr_i,
  input  logic [2:0]  m0_addr_tag_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_stb_i,
  input  logic [31:0] m1_addr_i,
  input  logic [2:0]  m1_addr_tag_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_data_o,
  output logic        s_stb_o,
  output logic [31:0] s_addr_o,
  output logic [2:0]  s_addr_tag_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic [31:0] s_data_i
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic          gnt_r;    // 0: m0 owns the bus, 1: m1
  logic          prio_r;   // requester that wins a tie
  logic [CW-1:0] cnt_r;

  logic elig0_s;
  logic elig1_s;
  logic pick_s;
  logic busy_s;
  logic resp_ack_s;
  logic resp_err_s;
  logic tmo_s;
  logic fin_s;
  logic err_s;

`ifdef IO_ARB_ATOMIC_LOCK_EN
  logic          lock_r;
  logic          owner_r;
  logic [CW-1:0] idle_cnt_r;
  logic          owner_stb_s;
  logic          unlock_s;
  logic          lock_s;
`endif

  // Eligibility, winner selection and completion decode for the current cycle
  always_comb begin
    elig0_s = m0_stb_i;
    elig1_s = m1_stb_i;
`ifdef IO_ARB_ATOMIC_LOCK_EN
    owner_stb_s = owner_r ? m1_stb_i : m0_stb_i;
    if (lock_r) begin
      elig0_s = m0_stb_i && !owner_r;
      elig1_s = m1_stb_i && owner_r;
    end else begin
      elig0_s = m0_stb_i;
      elig1_s = m1_stb_i;
    end
`endif
    if (elig0_s && elig1_s) begin
      pick_s = prio_r;
    end else begin
      pick_s = elig1_s;
    end
    busy_s     = (state_r == BUSY);
    // An error wins over a simultaneous ack
    resp_err_s = busy_s && s_err_i;
    resp_ack_s = busy_s && s_ack_i && !s_err_i;
    // A response on the last counted cycle takes precedence over the timeout
    tmo_s      = busy_s && !s_ack_i && !s_err_i && (cnt_r == TMAX);
    fin_s      = resp_ack_s || resp_err_s || tmo_s;
    err_s      = resp_err_s || tmo_s;
`ifdef IO_ARB_ATOMIC_LOCK_EN
    unlock_s = fin_s && lock_r && (owner_r == gnt_r) &&
               (err_s || (s_we_o && (s_addr_tag_o[2:1] == `ADDR_TAG_MODE_AMO) &&
                          (s_addr_tag_o[0] == `ADDR_TAG_UNLOCK)));
    lock_s   = resp_ack_s && !s_we_o && (s_addr_tag_o[2:1] == `ADDR_TAG_MODE_AMO) &&
               (s_addr_tag_o[0] == `ADDR_TAG_LOCK);
`endif
  end

  // Completion forwarding: only the granted requester sees ack/err/data
  assign m0_ack_o  = resp_ack_s && !gnt_r;
  assign m0_err_o  = err_s && !gnt_r;
  assign m0_data_o = (busy_s && !gnt_r) ? s_data_i : 32'h0000_0000;
  assign m1_ack_o  = resp_ack_s && gnt_r;
  assign m1_err_o  = err_s && gnt_r;
  assign m1_data_o = (busy_s && gnt_r) ? s_data_i : 32'h0000_0000;

  // Arbitration FSM, registered bus request and timeout counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r      <= IDLE;
      gnt_r        <= 1'b0;
      prio_r       <= 1'b0;
      cnt_r        <= '0;
      s_stb_o      <= 1'b0;
      s_addr_o     <= 32'h0000_0000;
      s_addr_tag_o <= 3'b000;
      s_data_o     <= 32'h0000_0000;
      s_sel_o      <= 4'b0000;
      s_we_o       <= 1'b0;
`ifdef IO_ARB_ATOMIC_LOCK_EN
      lock_r       <= 1'b0;
      owner_r      <= 1'b0;
      idle_cnt_r   <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (elig0_s || elig1_s) begin
            gnt_r        <= pick_s;
            s_stb_o      <= 1'b1;
            s_addr_o     <= pick_s ? m1_addr_i     : m0_addr_i;
            s_addr_tag_o <= pick_s ? m1_addr_tag_i : m0_addr_tag_i;
            s_data_o     <= pick_s ? m1_data_i     : m0_data_i;
            s_sel_o      <= pick_s ? m1_sel_i      : m0_sel_i;
            s_we_o       <= pick_s ? m1_we_i       : m0_we_i;
            cnt_r        <= '0;
            state_r      <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (fin_s) begin
            s_stb_o <= 1'b0;
            prio_r  <= ~gnt_r;
            state_r <= DONE;
          end else if (cnt_r != TMAX) begin
            cnt_r <= cnt_r + CW'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        DONE: begin
          // One settling cycle so the finished requester's strobe drop is visible
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          s_stb_o <= 1'b0;
        end
      endcase
`ifdef IO_ARB_ATOMIC_LOCK_EN
      if (unlock_s) begin
        lock_r <= 1'b0;
      end else if (lock_s) begin
        lock_r  <= 1'b1;
        owner_r <= gnt_r;
      end else if (lock_r && !busy_s && !owner_stb_s && (idle_cnt_r == TMAX)) begin
        lock_r <= 1'b0;
      end else begin
        lock_r <= lock_r;
      end
      if (lock_r && !busy_s && !owner_stb_s && (idle_cnt_r != TMAX)) begin
        idle_cnt_r <= idle_cnt_r + CW'(1);
      end else begin
        idle_cnt_r <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter with a transaction-level reference model.

`ifndef ADDR_TAG_MODE_AMO
`define ADDR_TAG_MODE_AMO 2'b01
`endif
`ifndef ADDR_TAG_LOCK
`define ADDR_TAG_LOCK 1'b1
`endif
`ifndef ADDR_TAG_UNLOCK
`define ADDR_TAG_UNLOCK 1'b0
`endif

module tb_io_bus_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_stb, m1_stb, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [2:0]  m0_tag, m1_tag;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_stb, s_we, s_ack, s_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [2:0]  s_tag;
  logic [3:0]  s_sel;

  int checks   = 0;
  int failures = 0;

  // Reference model state: requests held by each master and arbitration memory
  bit          pend[2];
  logic [31:0] addr[2];
  logic [31:0] wdat[2];
  logic [2:0]  tag[2];
  logic [3:0]  sel[2];
  logic        we[2];
  int          prio_m;
  bit          lock_m;
  int          lock_own;

  io_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_stb_i(m0_stb), .m0_addr_i(m0_addr), .m0_addr_tag_i(m0_tag), .m0_data_i(m0_wdata),
    .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_data_o(m0_rdata),
    .m1_stb_i(m1_stb), .m1_addr_i(m1_addr), .m1_addr_tag_i(m1_tag), .m1_data_i(m1_wdata),
    .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_data_o(m1_rdata),
    .s_stb_o(s_stb), .s_addr_o(s_addr), .s_addr_tag_o(s_tag), .s_data_o(s_wdata),
    .s_sel_o(s_sel), .s_we_o(s_we), .s_ack_i(s_ack), .s_err_i(s_err), .s_data_i(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic drive_masters();
    m0_stb = pend[0]; m0_addr = addr[0]; m0_tag = tag[0]; m0_wdata = wdat[0]; m0_sel = sel[0]; m0_we = we[0];
    m1_stb = pend[1]; m1_addr = addr[1]; m1_tag = tag[1]; m1_wdata = wdat[1]; m1_sel = sel[1]; m1_we = we[1];
  endtask

  task automatic new_req(input int n);
    pend[n] = 1'b1;
    addr[n] = $urandom;
    wdat[n] = $urandom;
    sel[n]  = 4'($urandom_range(1, 15));
    we[n]   = 1'($urandom_range(0, 1));
    tag[n]  = {($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00, 1'($urandom_range(0, 1))};
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s_ack = 1'b0; s_err = 1'b0; s_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; addr[i] = 32'h0; wdat[i] = 32'h0; tag[i] = 3'b000; sel[i] = 4'h0; we[i] = 1'b0;
    end
    drive_masters();
    prio_m = 0; lock_m = 1'b0; lock_own = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One complete transaction from an IDLE negedge: grant, slave latency, completion, DONE
  task automatic run_txn(input int lat, input bit use_err, input bit both, input logic [31:0] rdata);
    int w;
    bit responded;
    bit done;
    bit ok;
    logic [3:0] exp_v;
    logic [3:0] got_v;
    if (lock_m) w = lock_own;
    else if (pend[0] && pend[1]) w = prio_m;
    else w = pend[1] ? 1 : 0;
    drive_masters();
    @(negedge clk);
    checks++;
    if (s_stb !== 1'b1 || s_addr !== addr[w] || s_tag !== tag[w] || s_wdata !== wdat[w] ||
        s_sel !== sel[w] || s_we !== we[w]) begin
      failures++;
      $display("FAIL grant: stb=%b addr=%h tag=%b data=%h sel=%h we=%b required m%0d stb=1 addr=%h tag=%b data=%h sel=%h we=%b",
               s_stb, s_addr, s_tag, s_wdata, s_sel, s_we, w, addr[w], tag[w], wdat[w], sel[w], we[w]);
    end
    responded = 1'b0;
    done = 1'b0;
    for (int k = 0; k <= T && !done; k++) begin
      if (k > 0) begin
        @(negedge clk);
        checks++;
        if (s_stb !== 1'b1) begin
          failures++;
          $display("FAIL busy_stb: cycle %0d s_stb=%b required 1", k, s_stb);
        end
      end
      if (k == lat) begin
        s_ack = !use_err || both;
        s_err = use_err;
        s_rdata = rdata;
        responded = 1'b1;
      end
      #1;
      exp_v = 4'b0000;
      if (responded) exp_v[2*w + (use_err ? 1 : 0)] = 1'b1;
      else if (k == T) exp_v[2*w + 1] = 1'b1;
      got_v = {m1_err, m1_ack, m0_err, m0_ack};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL completion: cycle %0d {m1_err,m1_ack,m0_err,m0_ack}=%b required %b", k, got_v, exp_v);
      end
      ok = (w == 0) ? (m1_rdata === 32'h0 && (!responded || m0_rdata === rdata))
                    : (m0_rdata === 32'h0 && (!responded || m1_rdata === rdata));
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL read_data: cycle %0d m0_data=%h m1_data=%h required m%0d=%h other=0",
                 k, m0_rdata, m1_rdata, w, responded ? rdata : 32'h0);
      end
      done = responded || (k == T);
    end
    @(negedge clk);
    s_ack = 1'b0; s_err = 1'b0;
    pend[w] = 1'b0;
    drive_masters();
    #1;
    checks++;
    if (s_stb !== 1'b0 || {m1_err, m1_ack, m0_err, m0_ack} !== 4'b0000) begin
      failures++;
      $display("FAIL done_state: s_stb=%b acks/errs=%b required 0 and 0000", s_stb, {m1_err, m1_ack, m0_err, m0_ack});
    end
`ifdef IO_ARB_ATOMIC_LOCK_EN
    if (lock_m && lock_own == w &&
        (!responded || use_err || (we[w] && tag[w][2:1] == `ADDR_TAG_MODE_AMO && tag[w][0] == `ADDR_TAG_UNLOCK)))
      lock_m = 1'b0;
    else if (responded && !use_err && !we[w] && tag[w][2:1] == `ADDR_TAG_MODE_AMO && tag[w][0] == `ADDR_TAG_LOCK) begin
      lock_m = 1'b1;
      lock_own = w;
    end
`endif
    prio_m = 1 - w;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pend[0] = 1'b1; pend[1] = 1'b1; addr[0] = 32'h1234_5678; addr[1] = 32'h8765_4321;
    drive_masters();
    s_ack = 1'b1; s_err = 1'b1; s_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err} !== 6'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0 ||
        s_tag !== 3'b0 || s_sel !== 4'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: stb=%b addr=%h data=%h m0_data=%h m1_data=%h flags=%b required all 0",
               s_stb, s_addr, s_wdata, m0_rdata, m1_rdata, {s_we, m0_ack, m0_err, m1_ack, m1_err});
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    pend[0] = 1'b1; addr[0] = 32'h0000_1000; we[0] = 1'b0; sel[0] = 4'hF; tag[0] = 3'b000; wdat[0] = 32'h0;
    run_txn(2, 1'b0, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_contention();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n]) begin
          new_req(n);
          addr[n] = (n == 0) ? (32'hA000_0000 | 32'(i)) : (32'hB000_0000 | 32'(i));
        end
      end
      run_txn(1, 1'b0, 1'b0, $urandom);
    end
    run_txn(0, 1'b0, 1'b0, $urandom);
  endtask

  task automatic test_timeout();
    apply_reset();
    new_req(1);
    run_txn(T + 3, 1'b0, 1'b0, 32'h0);
    s_ack = 1'b1; s_err = 1'b1; s_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({m1_err, m1_ack, m0_err, m0_ack} !== 4'b0000 || s_stb !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
        failures++;
        $display("FAIL stray_response: cycle %0d flags=%b s_stb=%b m0_data=%h m1_data=%h required 0",
                 i, {m1_err, m1_ack, m0_err, m0_ack}, s_stb, m0_rdata, m1_rdata);
      end
      @(negedge clk);
    end
    s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int r = 0; r < 40; r++) begin
      for (int n = 0; n < 2; n++)
        if (!pend[n] && $urandom_range(0, 1) == 1) new_req(n);
      if (!pend[0] && !pend[1]) new_req($urandom_range(0, 1));
      run_txn($urandom_range(0, T + 2), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom);
    end
    while (pend[0] || pend[1]) run_txn(0, 1'b0, 1'b0, $urandom);
  endtask

`ifdef IO_ARB_ATOMIC_LOCK_EN
  task automatic test_lock();
    apply_reset();
    new_req(1); tag[1] = {`ADDR_TAG_MODE_AMO, `ADDR_TAG_LOCK}; we[1] = 1'b0;
    run_txn(1, 1'b0, 1'b0, $urandom);
    new_req(0);
    drive_masters();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_stb !== 1'b0) begin
        failures++;
        $display("FAIL lock_hold: cycle %0d s_stb=%b s_addr=%h required no grant", i, s_stb, s_addr);
      end
    end
    new_req(1); tag[1] = {`ADDR_TAG_MODE_AMO, `ADDR_TAG_UNLOCK}; we[1] = 1'b1;
    run_txn(2, 1'b0, 1'b0, $urandom);
    run_txn(1, 1'b0, 1'b0, $urandom);
  endtask
`endif

  task automatic test_reset_mid();
    apply_reset();
    new_req(0);
    drive_masters();
    @(negedge clk);
    checks++;
    if (s_stb !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_grant: s_stb=%b required 1", s_stb);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_stb !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_stb: s_stb=%b required 0 immediately", s_stb);
    end
    pend[0] = 1'b0;
    drive_masters();
    @(negedge clk);
    rst_n = 1'b1;
    s_ack = 1'b1; s_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({m1_err, m1_ack, m0_err, m0_ack} !== 4'b0000 || s_stb !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_quiet: cycle %0d flags=%b s_stb=%b required 0", i, {m1_err, m1_ack, m0_err, m0_ack}, s_stb);
      end
    end
    s_ack = 1'b0; s_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_random();
`ifdef IO_ARB_ATOMIC_LOCK_EN
    test_lock();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles a granted transaction waits for s_ack_i/s_err_i.
REQ-002 SHALL use a single clock and an asynchronous, active-low reset, with ports as follows.
REQ-003 clk_i  input  1  single clock; all state on its rising edge.
REQ-004 rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 mN_stb_i  input  1  requester N (N=0,1) strobe; held high until mN_ack_o or mN_err_o.
REQ-006 mN_addr_i  input  32  requester N address.
REQ-007 mN_addr_tag_i  input  3  requester N tag: [2:1] mode (`ADDR_TAG_MODE_*), [0] lock/unlock.
REQ-008 mN_data_i  input  32  requester N write data.
REQ-009 mN_sel_i  input  4  requester N byte select.
REQ-010 mN_we_i  input  1  requester N write enable.
REQ-011 mN_ack_o  output  1  requester N completion pulse.
REQ-012 mN_err_o  output  1  requester N error pulse (slave error or timeout).
REQ-013 mN_data_o  output  32  requester N read data, valid with mN_ack_o.
REQ-014 s_stb_o, s_addr_o[31:0], s_addr_tag_o[2:0], s_data_o[31:0], s_sel_o[3:0], s_we_o  output  shared IO bus request.
REQ-015 s_ack_i, s_err_i  input  1  IO bus completion/error; s_data_i  input  32  read data.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 IDLE: when any mN_stb_i is high, SHALL grant one requester and assert s_stb_o on the next edge (one-cycle request latency).
REQ-018 SHALL arbitrate round-robin: after a requester completes, the other has priority; with both requesting, the priority holder wins.
REQ-019 s_addr_o, s_addr_tag_o, s_data_o, s_sel_o and s_we_o SHALL be registered from the granted requester at grant and held stable through BUSY.
REQ-020 BUSY: s_ack_i or s_err_i SHALL be forwarded combinationally to the granted requester only (ack->mN_ack_o, err->mN_err_o), with mN_data_o = s_data_i; the other requester's outputs SHALL stay 0.
REQ-021 On ack/err in BUSY, SHALL deassert s_stb_o on the next edge and enter DONE; DONE SHALL return to IDLE after one cycle, so a requester's strobe drop is seen before re-arbitration.
REQ-022 SHALL count BUSY cycles; on reaching TIMEOUT_CYCLES without ack/err, SHALL pulse mN_err_o for one cycle, drop s_stb_o and enter DONE.
REQ-023 s_ack_i/s_err_i arriving outside BUSY SHALL be ignored.
REQ-024 Simultaneous s_ack_i and s_err_i SHALL be reported as err only.
REQ-025 A requester dropping mN_stb_i during BUSY SHALL NOT abort the bus transaction; its completion is still consumed.
REQ-026 Timeout counter SHALL be wide enough for TIMEOUT_CYCLES, SHALL clear on each grant and SHALL NOT wrap.

Reset
REQ-027 While rst_n_i is low, SHALL force state IDLE, priority to m0, lock cleared, counter 0, s_stb_o=0, all s_* outputs 0, and all mN_ack_o/mN_err_o/mN_data_o 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it; no ack/err SHALL be generated for it after reset release.

Configuration
REQ-029 Macro IO_ARB_ATOMIC_LOCK_EN: when defined, a completed read with mode `ADDR_TAG_MODE_AMO and tag[0]=`ADDR_TAG_LOCK SHALL lock the grant to that requester.
REQ-030 While locked, SHALL grant only the owner; lock SHALL release on completion of the owner's write tagged AMO/`ADDR_TAG_UNLOCK, on any error/timeout of the owner, or after TIMEOUT_CYCLES idle cycles without an owner request.
REQ-031 Without IO_ARB_ATOMIC_LOCK_EN, tags SHALL pass through unused and arbitration SHALL be pure round-robin.

Verification
REQ-032 m0 read 0x0000_1000, slave acks 2 cycles after s_stb_o, s_data_i=0xDEAD_BEEF -> m0_ack_o with m0_data_o=0xDEAD_BEEF; m1 outputs stay 0.
REQ-033 m0 and m1 request in the same cycle after reset -> m0 granted first, m1 second; repeated contention alternates.
REQ-034 Slave never responds, TIMEOUT_CYCLES=8 -> mN_err_o pulses 8 cycles after s_stb_o rises; a later s_ack_i is ignored.
REQ-035 With IO_ARB_ATOMIC_LOCK_EN: m1 AMO lock read, m0 requesting -> m0 is not granted until m1's AMO unlock write completes.
REQ-036 Assert rst_n_i low during BUSY -> s_stb_o falls immediately; after release, no ack/err pulse occurs.
